quad_decoder: RTL and testbench
===============================

QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of the position count.
REQ-002 SHALL have parameter MODULUS, default 24: count range 0..MODULUS-1, where 2 <= MODULUS <= 2^WIDTH.
REQ-003 SHALL have parameter FILT, default 4: consecutive stable cycles a synchronised input needs before it is accepted (FILT >= 1).
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have ports quad_a and quad_b, input, 1 bit each: asynchronous encoder phases.
REQ-007 SHALL have port index, input, 1 bit: asynchronous encoder index (Z) pulse.
REQ-008 SHALL have port mode, input, 2 bits: 00 selects x1, 01 selects x2, 10 and 11 select x4 decoding.
REQ-009 SHALL have port clr, input, 1 bit: synchronous count clear.
REQ-010 SHALL have port err_clr, input, 1 bit: clears the sticky error flag.
REQ-011 SHALL have port count, output, WIDTH bits: current position.
REQ-012 SHALL have port dir, output, 1 bit: direction of the last counted step (1 = up).
REQ-013 SHALL have port step, output, 1 bit: one-cycle pulse when count changes by a step.
REQ-014 SHALL have port err, output, 1 bit: sticky illegal-transition flag.
REQ-015 SHALL have port index_seen, output, 1 bit: sticky flag, set once an index load has occurred.

Function
REQ-016 SHALL pass quad_a, quad_b and index each through a 2-flop synchroniser followed by a filter that updates the accepted value only after FILT consecutive equal synchronised samples.
REQ-017 SHALL treat the filtered pair {A,B} as Gray-coded; up sequence is 00 -> 10 -> 11 -> 01 -> 00, and the reverse is down.
REQ-018 SHALL, in x4 mode, count every legal transition.
REQ-019 SHALL, in x2 mode, count only A-changing transitions: 00->10 and 11->01 up; 10->00 and 01->11 down.
REQ-020 SHALL, in x1 mode, count only 00->10 as up and 10->00 as down.
REQ-021 SHALL treat a simultaneous change of A and B as illegal: no count, and err is set.
REQ-022 SHALL wrap count: up from MODULUS-1 goes to 0; down from 0 goes to MODULUS-1.
REQ-023 SHALL register count, dir and step in the cycle after the filtered state changes; latency from an input edge to count is 2 + FILT + 1 cycles.
REQ-024 SHALL hold dir at its last value when no step occurs.
REQ-025 SHALL, when clr = 1, set count to 0 and suppress step in that cycle; clr overrides the index load and any step.
REQ-026 SHALL leave the filtered state tracking inputs during clr, so that no step is lost or double-counted after clr deasserts.
REQ-027 SHALL give err_clr priority over a simultaneous error set, so err reads 0 in the next cycle.
REQ-028 SHALL take a mode change effective on the next decoded transition, without altering count.

Reset
REQ-029 SHALL, while rst_n = 0, set count = 0, dir = 0, step = 0, err = 0 and index_seen = 0, and clear the synchronisers, filters and armed flag.
REQ-030 SHALL, on the first filtered value accepted after reset, adopt that value as the decoder state without counting or flagging an error (arming).
REQ-031 SHALL, when reset is asserted mid-rotation, discard any in-flight filter progress; counting resumes only after re-arming.

Configuration
REQ-032 SHALL, with macro QUAD_DECODER_INDEX_EN defined, on a rising edge of the filtered index load count = 0, set index_seen and suppress any step in that cycle; clr still has priority.
REQ-033 SHALL, without QUAD_DECODER_INDEX_EN, keep the index port present but ignored, tie index_seen to 0, and omit the index synchroniser and filter logic.

Verification
REQ-034 SHALL cover: MODULUS=24, x4 mode, 30 up Gray steps each held 8 cycles -> count = 6, dir = 1, 30 step pulses.
REQ-035 SHALL cover: from count 0, one down step in x4 mode -> count = 23, dir = 0.
REQ-036 SHALL cover: x1 mode, 4 full up cycles (16 edges) -> count = 4; x2 mode, the same stimulus -> count = 8.
REQ-037 SHALL cover: 00 -> 11 jump -> err = 1 and count unchanged; err_clr pulse -> err = 0; glitch shorter than FILT cycles -> no change.
REQ-038 SHALL cover: with QUAD_DECODER_INDEX_EN defined, count 17 and an index rising edge -> count = 0, index_seen = 1; the same cycle with clr = 1 -> count = 0 and no step.
REQ-039 SHALL cover: inputs at 11 during reset release -> no step and no err after arming; the next legal step counts normally.

Source files
------------

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder with input synchronisation, glitch filtering,
// x1/x2/x4 decoding, modulo position count and sticky illegal-transition flag.
//
// Optional feature: define QUAD_DECODER_INDEX_EN to enable the index (Z)
// input, which zeroes the count on a rising edge of the filtered index and
// sets index_seen. Without it, index is ignored and index_seen is tied to 0.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   quad_a, quad_b   asynchronous encoder phases
//   index            asynchronous index pulse
//   mode             00 = x1, 01 = x2, 1x = x4
//   clr              synchronous count clear (overrides index load and steps)
//   err_clr          clears err (wins over a simultaneous error)
//   count            position, 0..MODULUS-1
//   dir              direction of last counted step (1 = up)
//   step             one-cycle pulse per counted step
//   err              sticky illegal-transition flag
//   index_seen       sticky flag, set after an index load
module quad_decoder #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MODULUS = 24,
  parameter int unsigned FILT    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             index,
  input  logic [1:0]       mode,
  input  logic             clr,
  input  logic             err_clr,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err,
  output logic             index_seen
);

  localparam int unsigned RW = $clog2(FILT + 1);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

`ifdef QUAD_DECODER_INDEX_EN
  localparam int unsigned NIN = 3;
  logic [NIN-1:0] raw;
  assign raw = {index, quad_b, quad_a};
`else
  localparam int unsigned NIN = 2;
  logic [NIN-1:0] raw;
  logic           unused_index;
  assign raw          = {quad_b, quad_a};
  assign unused_index = index;
`endif

  logic [NIN-1:0] s1, s2, cand, acc, vld;
  logic [RW-1:0]  run     [NIN];
  logic [RW-1:0]  run_nxt [NIN];
  logic [1:0]     fill;

  // Consecutive-sample run length of each synchronised input (saturating).
  always_comb begin
    for (int i = 0; i < NIN; i++) begin
      run_nxt[i] = RW'(1);
      if (s2[i] == cand[i] && run[i] != '0) begin
        run_nxt[i] = (run[i] >= RW'(FILT)) ? run[i] : run[i] + RW'(1);
      end
    end
  end

  // Synchronisers and filters; fill gates sampling until s2 holds real data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      cand <= '0;
      acc  <= '0;
      vld  <= '0;
      fill <= '0;
      for (int i = 0; i < NIN; i++) run[i] <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      fill <= {fill[0], 1'b1};
      if (fill[1]) begin
        cand <= s2;
        for (int i = 0; i < NIN; i++) begin
          run[i] <= run_nxt[i];
          if (run_nxt[i] == RW'(FILT)) begin
            acc[i] <= s2[i];
            vld[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Position of an {A,B} pair along the up sequence 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   gray_pos = 2'd0;
      2'b10:   gray_pos = 2'd1;
      2'b11:   gray_pos = 2'd2;
      default: gray_pos = 2'd3;
    endcase
  endfunction

  logic [1:0] cur, st, delta;
  logic       armed, ab_vld;
  logic       mv_c, up_c, bad_c, sel_c, step_c, idx_rise_c;

  assign cur    = {acc[0], acc[1]};
  assign ab_vld = vld[0] & vld[1];
  assign delta  = gray_pos(cur) - gray_pos(st);

  // Transition decode and mode qualification.
  always_comb begin
    mv_c  = 1'b0;
    up_c  = 1'b0;
    bad_c = 1'b0;
    sel_c = 1'b0;
    if (armed && cur != st) begin
      case (delta)
        2'd1:    begin mv_c = 1'b1; up_c = 1'b1; end
        2'd3:    mv_c  = 1'b1;
        default: bad_c = 1'b1;
      endcase
    end
    if (mode[1])      sel_c = 1'b1;
    else if (mode[0]) sel_c = cur[1] ^ st[1];
    else              sel_c = (st == 2'b00 && cur == 2'b10) || (st == 2'b10 && cur == 2'b00);
    step_c = mv_c & sel_c;
  end

`ifdef QUAD_DECODER_INDEX_EN
  logic idx_prev;
  assign idx_rise_c = vld[2] & acc[2] & ~idx_prev;

  // Index edge detect and sticky index_seen; clr blocks the load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_prev   <= 1'b0;
      index_seen <= 1'b0;
    end else begin
      idx_prev <= acc[2];
      if (idx_rise_c && !clr) index_seen <= 1'b1;
    end
  end
`else
  assign idx_rise_c = 1'b0;
  assign index_seen = 1'b0;
`endif

  // Decoder state tracking, arming, count/dir/step and error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st    <= 2'b00;
      armed <= 1'b0;
      count <= '0;
      dir   <= 1'b0;
      step  <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (armed) begin
        st <= cur;
      end else if (ab_vld) begin
        st    <= cur;
        armed <= 1'b1;
      end

      if (err_clr)    err <= 1'b0;
      else if (bad_c) err <= 1'b1;

      step <= 1'b0;
      if (clr) begin
        count <= '0;
      end else if (idx_rise_c) begin
        count <= '0;
      end else if (step_c) begin
        step <= 1'b1;
        dir  <= up_c;
        if (up_c) count <= (count == MAX_CNT) ? '0 : count + WIDTH'(1);
        else      count <= (count == '0) ? MAX_CNT : count - WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder (WIDTH=8, MODULUS=24, FILT=4).
// Expected values come from a phase-based reference model of the encoder.
module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       rst_n, quad_a, quad_b, index, clr, err_clr;
  logic [1:0] mode;
  logic [7:0] count;
  logic       dir, step, err, index_seen;

  quad_decoder #(.WIDTH(8), .MODULUS(24), .FILT(4)) dut (
    .clk(clk), .rst_n(rst_n), .quad_a(quad_a), .quad_b(quad_b), .index(index),
    .mode(mode), .clr(clr), .err_clr(err_clr), .count(count), .dir(dir),
    .step(step), .err(err), .index_seen(index_seen)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;
  int nsteps = 0;

  always @(negedge clk) if (step === 1'b1) nsteps++;

  // Reference model state
  logic [1:0] gray_ab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int ph     = 0;
  int mcount = 0;
  int mdir   = 0;
  int msteps = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_ph(input int p);
    logic [1:0] ab;
    ab = gray_ab[p];
    quad_a = ab[1];
    quad_b = ab[0];
  endtask

  // One Gray move; the model decides from the mode whether it counts.
  task automatic do_move(input bit up, input int hold);
    bit counts;
    if (mode[1])      counts = 1'b1;
    else if (mode[0]) counts = up ? (ph == 0 || ph == 2) : (ph == 1 || ph == 3);
    else              counts = up ? (ph == 0) : (ph == 1);
    if (counts) begin
      mcount = up ? (mcount + 1) % 24 : (mcount + 23) % 24;
      mdir   = up;
      msteps++;
    end
    ph = up ? (ph + 1) % 4 : (ph + 3) % 4;
    drive_ph(ph);
    tick(hold);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    mcount = 0;
  endtask

  initial begin
    int s0;
    rst_n = 1'b0; quad_a = 1'b0; quad_b = 1'b0; index = 1'b0;
    clr = 1'b0; err_clr = 1'b0; mode = 2'b10;
    tick(4);
    check("rst_count", count, 0);
    check("rst_dir", dir, 0);
    check("rst_step", step, 0);
    check("rst_err", err, 0);
    check("rst_index_seen", index_seen, 0);
    rst_n = 1'b1;
    tick(12);
    check("arm_count", count, 0);
    check("arm_err", err, 0);

    // 30 up steps in x4
    s0 = nsteps;
    for (int i = 0; i < 30; i++) do_move(1'b1, 8);
    check("x4_up30_count", count, 6);
    check("x4_up30_dir", dir, 1);
    check("x4_up30_steps", nsteps - s0, 30);

    // clear then one down step wraps to 23
    s0 = nsteps;
    pulse_clr();
    tick(2);
    check("clr_count", count, 0);
    check("clr_nostep", nsteps - s0, 0);
    do_move(1'b0, 8);
    check("down_wrap_count", count, 23);
    check("down_wrap_dir", dir, 0);

    // x1 and x2 over 16 edges each
    mode = 2'b00;
    pulse_clr();
    for (int i = 0; i < 16; i++) do_move(1'b1, 8);
    check("x1_count", count, 4);
    mode = 2'b01;
    pulse_clr();
    for (int i = 0; i < 16; i++) do_move(1'b1, 8);
    check("x2_count", count, 8);

    // illegal 00 -> 11 jump
    mode = 2'b10;
    while (ph != 0) do_move(1'b1, 8);
    s0 = nsteps;
    ph = 2;
    drive_ph(ph);
    tick(10);
    check("illegal_err", err, 1);
    check("illegal_count", count, mcount);
    check("illegal_nostep", nsteps - s0, 0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("err_clr", err, 0);

    // glitch of FILT-1 cycles on A is rejected
    s0 = nsteps;
    quad_a = ~quad_a;
    tick(3);
    quad_a = ~quad_a;
    tick(10);
    check("glitch_count", count, mcount);
    check("glitch_nostep", nsteps - s0, 0);
    check("glitch_err", err, 0);

`ifdef QUAD_DECODER_INDEX_EN
    pulse_clr();
    for (int i = 0; i < 17; i++) do_move(1'b1, 8);
    check("pre_index_count", count, 17);
    index = 1'b1;
    tick(10);
    mcount = 0;
    check("index_count", count, 0);
    check("index_seen", index_seen, 1);
    index = 1'b0;
    tick(10);
    do_move(1'b1, 8);
    check("post_index_count", count, mcount);
    s0 = nsteps;
    clr = 1'b1;
    index = 1'b1;
    tick(10);
    clr = 1'b0;
    mcount = 0;
    check("index_clr_count", count, 0);
    check("index_clr_nostep", nsteps - s0, 0);
    index = 1'b0;
    tick(10);
`else
    s0 = count;
    index = 1'b1;
    tick(10);
    index = 1'b0;
    tick(10);
    check("index_ignored_count", count, s0);
    check("index_seen_tied", index_seen, 0);
`endif

    // randomized moves with random mode changes
    msteps = 0;
    s0 = nsteps;
    for (int i = 0; i < 60; i++) begin
      mode = 2'($urandom_range(0, 3));
      do_move(1'($urandom_range(0, 1)), int'($urandom_range(8, 12)));
      check("rand_count", count, mcount);
      check("rand_dir", dir, mdir);
    end
    check("rand_steps", nsteps - s0, msteps);
    check("rand_err", err, 0);

    // reset mid-move with inputs at 11; re-arm without count or error
    mode = 2'b10;
    while (ph != 1) do_move(1'b1, 8);
    ph = 2;
    drive_ph(ph);
    tick(3);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    mcount = 0;
    mdir = 0;
    s0 = nsteps;
    tick(12);
    check("rearm_count", count, 0);
    check("rearm_err", err, 0);
    check("rearm_nostep", nsteps - s0, 0);
    do_move(1'b1, 8);
    check("rearm_step_count", count, 1);
    check("rearm_step_dir", dir, 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
